instr_mem_fetch: RTL and testbench
==================================

Name: instr_mem_fetch

Overview:
- Stage directly downstream of the PC register. Consumes the 30-bit word-address PC and issues a byte-addressed read to instruction memory over a req/ack handshake.
- Captures the returned word into a one-entry output register and presents it to decode with a valid/ready handshake.
- Pulses pc_advance so the PC register loads its next value once the fetch completes.

Parameters:
- ADDR_W, 30, PC word-address width; mem_addr is ADDR_W+2 bits.
- DATA_W, 32, instruction width.
- TIMEOUT_CYC, 16, maximum WAIT cycles without mem_ack; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_word  in  ADDR_W  current PC word address from PC register
- pc_valid  in  1  pc_word valid, fetch requested
- flush  in  1  synchronous discard of in-flight or held instruction
- pc_advance  out  1  one-cycle pulse: PC register loads next PC
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W+2  byte address {pc_word,2'b00}
- mem_ack  in  1  memory data valid / request accepted
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1
- instr  out  DATA_W  fetched instruction
- instr_valid  out  1  instr valid to decode
- instr_ready  in  1  decode accepts instr
- fetch_err  out  1  sticky fetch timeout flag (FETCH_TIMEOUT_EN only)

Behaviour:
- Reset, asynchronous: state=IDLE, mem_req=0, mem_addr=0, instr=0, instr_valid=0, pc_advance=0, fetch_err=0, discard=0, timeout counter=0. Reset asserted mid-fetch drops mem_req immediately; any late mem_ack is ignored after release.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - pc_valid=1 and flush=0: mem_addr<={pc_word,2'b00}, mem_req<=1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - mem_req stays 1 and mem_addr stays stable until mem_ack. A request is never withdrawn, including on flush.
  - mem_ack=1 and discard=0 and flush=0: instr<=mem_rdata, instr_valid<=1, pc_advance<=1 for one cycle, mem_req<=0, go to HOLD.
  - mem_ack=1 with discard=1 or flush=1: data dropped, no pc_advance, mem_req<=0, discard<=0, go to IDLE.
  - flush=1 without mem_ack: discard<=1, stay in WAIT.
- HOLD:
  - instr and instr_valid stay stable until instr_ready.
  - instr_ready=1 and pc_valid=1: instr_valid<=0 and a new request issues on the same edge (mem_req=1 next cycle, back-to-back), go to WAIT.
  - instr_ready=1 and pc_valid=0: instr_valid<=0, go to IDLE.
  - flush=1: instr_valid<=0, go to IDLE. Flush wins over instr_ready; no new request that cycle.
- Latency:
  - pc_valid seen at edge N gives mem_req=1 after edge N.
  - mem_ack sampled at edge M gives instr_valid=1 and pc_advance=1 after edge M.
  - Minimum is 2 cycles from pc_valid to instr_valid (ack in the first cycle of mem_req).
- pc_advance fires exactly once per delivered instruction and never for discarded fetches.
- mem_ack outside WAIT is ignored.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - Counter increments each WAIT cycle without mem_ack and clears on entering WAIT.
  - At count==TIMEOUT_CYC: mem_req<=0, fetch_err<=1 (sticky), enter ERR.
  - ERR issues nothing, holds instr_valid=0, and leaves only via rst_n.
  - mem_ack in the same cycle the count hits the limit is honoured; ack wins.
- Not defined: fetch_err tied 0, no counter, WAIT waits indefinitely.

Test Plan:
- Reset, then pc_word=30'h0010_0008, pc_valid=1, memory acks after 1 cycle with 32'h8C22_0004 -> mem_addr=32'h0040_0020, instr=32'h8C22_0004, instr_valid 2 cycles after pc_valid, one pc_advance pulse.
- instr_ready=0 for 3 cycles with pc_valid=1 -> instr and instr_valid stable, no new mem_req; on instr_ready=1, mem_req rises the next cycle for the next pc_word (32'h0040_0024).
- flush pulsed in WAIT, ack 2 cycles later with 32'hDEAD_BEEF -> mem_req held until ack, instr_valid stays 0, no pc_advance, return to IDLE.
- rst_n asserted while mem_req=1 -> mem_req=0 without a clock edge; subsequent mem_ack produces no instr_valid.
- FETCH_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ack never asserted -> fetch_err=1 after 16 WAIT cycles, mem_req=0, sticky until rst_n.
- Same build, ack on the 16th WAIT cycle -> instr delivered, fetch_err stays 0.

Source files
------------

// File: rtl/instr_mem_fetch_if.sv
// Fetch-stage bus: PC register side, instruction memory side and decode side.
// The master modport is the fetch stage; the slave modport is its environment.
interface instr_mem_fetch_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_word;
  logic              pc_valid;
  logic              flush;
  logic              pc_advance;
  logic              mem_req;
  logic [ADDR_W+1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              fetch_err;

  modport master (
    input  pc_word, pc_valid, flush, mem_ack, mem_rdata, instr_ready,
    output pc_advance, mem_req, mem_addr, instr, instr_valid, fetch_err
  );

  modport slave (
    output pc_word, pc_valid, flush, mem_ack, mem_rdata, instr_ready,
    input  pc_advance, mem_req, mem_addr, instr, instr_valid, fetch_err
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Instruction fetch: PC word -> byte-addressed req/ack read -> one-entry valid/ready holding register.
// 2 cycles pc_valid->instr_valid minimum; stalls in HOLD while instr_ready=0; FETCH_TIMEOUT_EN adds a WAIT watchdog.
module instr_mem_fetch #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input logic               clk,
  input logic               rst_n,
  instr_mem_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              vld_q, vld_d;
  logic              adv_q, adv_d;
  logic              discard_q, discard_d;
  logic              err_q, err_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    vld_d     = vld_q;
    adv_d     = 1'b0;
    discard_d = discard_q;
    err_d     = err_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.pc_valid && !bus.flush) begin
          addr_d    = {bus.pc_word, 2'b00};
          req_d     = 1'b1;
          discard_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d     = '0;
`endif
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        // A request is never withdrawn; a flush only marks the returning data for discard.
        if (bus.mem_ack) begin
          req_d = 1'b0;
          if (discard_q || bus.flush) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            instr_d = bus.mem_rdata;
            vld_d   = 1'b1;
            adv_d   = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          if (bus.flush) begin
            discard_d = 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_ERR;
          end
`endif
        end
      end

      S_HOLD: begin
        if (bus.flush) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end else if (bus.instr_ready) begin
          vld_d = 1'b0;
          if (bus.pc_valid) begin
            addr_d    = {bus.pc_word, 2'b00};
            req_d     = 1'b1;
            discard_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt_d     = '0;
`endif
            state_d   = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_ERR: begin
        req_d = 1'b0;
        vld_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      instr_q   <= '0;
      vld_q     <= 1'b0;
      adv_q     <= 1'b0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      vld_q     <= vld_d;
      adv_q     <= adv_d;
      discard_q <= discard_d;
      err_q     <= err_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc_advance  = adv_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch; inputs change and outputs are checked 1ns after each rising edge.
module tb_instr_mem_fetch;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   adv_cnt;

  instr_mem_fetch_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  instr_mem_fetch #(.ADDR_W(30), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.pc_advance === 1'b1) adv_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    adv_cnt = 0;
    rst_n           = 1'b0;
    bus.pc_word     = '0;
    bus.pc_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.instr_ready = 1'b0;
    #1;
    chk("rst_mem_req",     64'(bus.mem_req),     64'd0);
    chk("rst_mem_addr",    64'(bus.mem_addr),    64'd0);
    chk("rst_instr",       64'(bus.instr),       64'd0);
    chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_pc_advance",  64'(bus.pc_advance),  64'd0);
    chk("rst_fetch_err",   64'(bus.fetch_err),   64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic fetch, ack in the first request cycle
    bus.pc_word  = 30'h0010_0008;
    bus.pc_valid = 1'b1;
    step();
    chk("t1_mem_req",  64'(bus.mem_req),     64'd1);
    chk("t1_mem_addr", 64'(bus.mem_addr),    64'h0040_0020);
    chk("t1_vld_low",  64'(bus.instr_valid), 64'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8C22_0004;
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.pc_word   = 30'h0010_0009;
    chk("t1_instr",      64'(bus.instr),       64'h8C22_0004);
    chk("t1_instr_vld",  64'(bus.instr_valid), 64'd1);
    chk("t1_pc_advance", 64'(bus.pc_advance),  64'd1);
    chk("t1_req_drop",   64'(bus.mem_req),     64'd0);

    // Decode stall for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_instr", 64'(bus.instr),       64'h8C22_0004);
      chk("t2_hold_vld",   64'(bus.instr_valid), 64'd1);
      chk("t2_no_req",     64'(bus.mem_req),     64'd0);
      chk("t2_adv_once",   64'(bus.pc_advance),  64'd0);
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("t2_b2b_req",  64'(bus.mem_req),     64'd1);
    chk("t2_b2b_addr", 64'(bus.mem_addr),    64'h0040_0024);
    chk("t2_vld_drop", 64'(bus.instr_valid), 64'd0);

    // Flush while waiting: request held, data dropped
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.pc_valid = 1'b0;
    chk("t3_req_held",  64'(bus.mem_req),  64'd1);
    chk("t3_addr_held", 64'(bus.mem_addr), 64'h0040_0024);
    step();
    chk("t3_req_held2", 64'(bus.mem_req), 64'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_ack = 1'b0;
    chk("t3_req_drop", 64'(bus.mem_req),     64'd0);
    chk("t3_no_vld",   64'(bus.instr_valid), 64'd0);
    chk("t3_no_adv",   64'(bus.pc_advance),  64'd0);
    step();
    chk("t3_idle_req", 64'(bus.mem_req),     64'd0);
    chk("t3_idle_vld", 64'(bus.instr_valid), 64'd0);

    // Asynchronous reset mid-fetch
    bus.pc_word  = 30'h0000_0100;
    bus.pc_valid = 1'b1;
    step();
    chk("t4_req",  64'(bus.mem_req),  64'd1);
    chk("t4_addr", 64'(bus.mem_addr), 64'h0000_0400);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_req",  64'(bus.mem_req),  64'd0);
    chk("t4_async_addr", 64'(bus.mem_addr), 64'd0);
    bus.pc_valid  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    step();
    rst_n = 1'b1;
    step();
    chk("t4_late_ack_vld", 64'(bus.instr_valid), 64'd0);
    chk("t4_late_ack_req", 64'(bus.mem_req),     64'd0);
    bus.mem_ack = 1'b0;

    // Flush in HOLD wins over instr_ready
    bus.pc_word  = 30'h0000_0200;
    bus.pc_valid = 1'b1;
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_ack = 1'b0;
    chk("t5_instr", 64'(bus.instr),       64'h1234_5678);
    chk("t5_vld",   64'(bus.instr_valid), 64'd1);
    bus.flush       = 1'b1;
    bus.instr_ready = 1'b1;
    step();
    chk("t5_flush_vld", 64'(bus.instr_valid), 64'd0);
    chk("t5_flush_req", 64'(bus.mem_req),     64'd0);
    bus.flush       = 1'b0;
    bus.pc_valid    = 1'b0;
    bus.instr_ready = 1'b0;
    step();
    chk("t5_idle_req", 64'(bus.mem_req), 64'd0);

    // Accept with no pending PC returns to IDLE
    bus.pc_word  = 30'h0000_0300;
    bus.pc_valid = 1'b1;
    step();
    chk("t6_addr", 64'(bus.mem_addr), 64'h0000_0C00);
    bus.pc_valid  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hAABB_CCDD;
    step();
    bus.mem_ack = 1'b0;
    chk("t6_instr", 64'(bus.instr), 64'hAABB_CCDD);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("t6_vld_drop", 64'(bus.instr_valid), 64'd0);
    chk("t6_no_req",   64'(bus.mem_req),     64'd0);

    // Flush blocks a request from IDLE
    bus.pc_valid = 1'b1;
    bus.flush    = 1'b1;
    step();
    chk("t7_flush_idle", 64'(bus.mem_req), 64'd0);
    bus.pc_valid = 1'b0;
    bus.flush    = 1'b0;
    step();

`ifdef FETCH_TIMEOUT_EN
    // Watchdog fires after 16 unanswered WAIT cycles
    bus.pc_word  = 30'h0000_0400;
    bus.pc_valid = 1'b1;
    step();
    bus.pc_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("to_req_c15", 64'(bus.mem_req),   64'd1);
    chk("to_err_c15", 64'(bus.fetch_err), 64'd0);
    step();
    chk("to_err",     64'(bus.fetch_err), 64'd1);
    chk("to_req_off", 64'(bus.mem_req),   64'd0);
    bus.pc_valid = 1'b1;
    bus.mem_ack  = 1'b1;
    step();
    step();
    bus.mem_ack = 1'b0;
    chk("to_sticky",   64'(bus.fetch_err),   64'd1);
    chk("to_err_req",  64'(bus.mem_req),     64'd0);
    chk("to_err_vld",  64'(bus.instr_valid), 64'd0);
    bus.pc_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("to_rst_clr", 64'(bus.fetch_err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Ack on the 16th WAIT cycle is honoured
    bus.pc_valid = 1'b1;
    step();
    bus.pc_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    step();
    bus.mem_ack = 1'b0;
    chk("to_edge_vld",   64'(bus.instr_valid), 64'd1);
    chk("to_edge_instr", 64'(bus.instr),       64'h0BAD_F00D);
    chk("to_edge_err",   64'(bus.fetch_err),   64'd0);
    step();
    chk("adv_total", 64'(adv_cnt), 64'd4);
`else
    step();
    chk("adv_total", 64'(adv_cnt), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
